inst_rom_boot: RTL and testbench

INST_ROM_BOOT -- requirements
Module: inst_rom_boot

---
 rtl/inst_rom_boot.sv | 151 +++++++++++++++
 tb/tb_inst_rom_boot.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_boot.sv
// rtl/inst_rom_boot.sv - boot-loadable instruction ROM with byte-stream loader
module inst_rom_boot #(
  parameter int AW = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rom_ce_i,
  input  logic [31:0] rom_addr_i,
  output logic [31:0] rom_data_o,
  input  logic        load_start_i,
  input  logic        load_valid_i,
  input  logic [7:0]  load_byte_i,
  output logic        load_ready_o,
  output logic        load_done_o,
  output logic        load_err_o,
  output logic        cpu_hold_o
);

  localparam int DEPTH = 1 << AW;

  // Word-address counter is one bit wider than a 16-bit count so it never wraps.
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [15:0] words_left;
  logic [7:0]  len_hi;
  logic [1:0]  byte_cnt;
  logic [23:0] asm_word;
  logic [16:0] wr_addr;
  logic [31:0] mem [DEPTH];

  logic        xfer;
  logic        word_last_byte;
  logic        word_in_range;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [15:0] len_full;

  // Handshake and status outputs decoded straight from the state.
  assign load_ready_o   = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA);
  assign load_done_o    = (state == S_DONE);
  assign cpu_hold_o     = (state != S_IDLE);
  assign xfer           = load_valid_i && load_ready_o;
  assign len_full       = {len_hi, load_byte_i};
  assign word_last_byte = (state == S_DATA) && xfer && (byte_cnt == 2'd3);
  assign word_in_range  = (wr_addr < DEPTH_W);
  assign wr_en          = word_last_byte && word_in_range;
  assign wr_data        = {asm_word, load_byte_i};

  // Next-state decode for the loader.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (load_start_i) state_nxt = S_LEN_HI;
      S_LEN_HI: if (xfer) state_nxt = S_LEN_LO;
      S_LEN_LO: if (xfer) state_nxt = (len_full == 16'd0) ? S_DONE : S_DATA;
      S_DATA:   if (word_last_byte && (words_left == 16'd1)) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Length capture, byte assembly and word/byte counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_hi     <= 8'd0;
      words_left <= 16'd0;
      byte_cnt   <= 2'd0;
      asm_word   <= 24'd0;
      wr_addr    <= 17'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_start_i) begin
            len_hi     <= 8'd0;
            words_left <= 16'd0;
            byte_cnt   <= 2'd0;
            asm_word   <= 24'd0;
            wr_addr    <= 17'd0;
          end
        end
        S_LEN_HI: begin
          if (xfer) len_hi <= load_byte_i;
        end
        S_LEN_LO: begin
          if (xfer) words_left <= len_full;
        end
        S_DATA: begin
          if (xfer) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0:    asm_word[23:16] <= load_byte_i;
              2'd1:    asm_word[15:8]  <= load_byte_i;
              2'd2:    asm_word[7:0]   <= load_byte_i;
              default: begin
                wr_addr    <= wr_addr + 17'd1;
                words_left <= words_left - 16'd1;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  // Overflow flag: set by any word beyond the array, cleared by the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_err_o <= 1'b0;
    end else if ((state == S_IDLE) && load_start_i) begin
      load_err_o <= 1'b0;
    end else if (word_last_byte && !word_in_range) begin
      load_err_o <= 1'b1;
    end
  end

  // Instruction storage; reset clears every word so fetches return NOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else if (wr_en) begin
      mem[wr_addr[AW-1:0]] <= wr_data;
    end
  end

  // Zero-latency fetch port; returns NOP while loading or when out of range.
  always_comb begin
    rom_data_o = 32'd0;
    if (rom_ce_i && (state == S_IDLE) && (rom_addr_i[31:AW+2] == '0)) begin
      rom_data_o = mem[rom_addr_i[AW+1:2]];
    end
  end

endmodule

// File: tb/tb_inst_rom_boot.sv
// tb/tb_inst_rom_boot.sv - randomized self-checking bench for inst_rom_boot
module tb_inst_rom_boot;

  logic        clk;
  logic        rst;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        load_start_i;
  logic        load_valid_i;
  logic [7:0]  load_byte_i;
  logic        load_ready_o;
  logic        load_done_o;
  logic        load_err_o;
  logic        cpu_hold_o;

  int tests_run;
  int tests_failed;

  logic [31:0] model_mem [64];
  logic        model_err;
  logic [31:0] wq [$];

  inst_rom_boot #(.AW(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .rom_ce_i     (rom_ce_i),
    .rom_addr_i   (rom_addr_i),
    .rom_data_o   (rom_data_o),
    .load_start_i (load_start_i),
    .load_valid_i (load_valid_i),
    .load_byte_i  (load_byte_i),
    .load_ready_o (load_ready_o),
    .load_done_o  (load_done_o),
    .load_err_o   (load_err_o),
    .cpu_hold_o   (cpu_hold_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) model_mem[i] = 32'd0;
    model_err = 1'b0;
  endtask

  // Expected fetch result from the reference memory image.
  function automatic logic [31:0] model_fetch(input logic [31:0] addr);
    if (addr >= 32'd256) return 32'd0;
    return model_mem[addr / 4];
  endfunction

  task automatic fetch(input string tag, input logic [31:0] addr);
    @(negedge clk);
    rom_ce_i   = 1'b1;
    rom_addr_i = addr;
    #1;
    check(tag, rom_data_o, model_fetch(addr));
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_hold", {31'd0, cpu_hold_o}, 32'd0);
    check("rst_ready", {31'd0, load_ready_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      load_valid_i = 1'b0;
      @(negedge clk);
      check("hold_gap", {31'd0, cpu_hold_o}, 32'd1);
      @(posedge clk); #1;
    end
    load_byte_i  = b;
    load_valid_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (!load_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!load_ready_o) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    load_valid_i = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    load_start_i = 1'b1;
    @(posedge clk); #1;
    load_start_i = 1'b0;
  endtask

  // Full load of wq[0..cnt-1]; gap_max>0 randomizes idle cycles between bytes.
  task automatic run_load(input int cnt, input int gap_max, input bit start_mid);
    pulse_start();
    rom_ce_i   = 1'b1;
    rom_addr_i = 32'd0;
    #1;
    check("fetch_busy", rom_data_o, 32'd0);
    send_byte(8'(cnt >> 8), gap_max == 0 ? 0 : $urandom_range(gap_max, 1));
    send_byte(8'(cnt), gap_max == 0 ? 0 : $urandom_range(gap_max, 1));
    for (int w = 0; w < cnt; w++) begin
      for (int k = 3; k >= 0; k--) begin
        send_byte(8'(wq[w] >> (8 * k)), gap_max == 0 ? 0 : $urandom_range(gap_max, 0));
        if (start_mid && w == 0 && k == 3) begin
          load_start_i = 1'b1;
          @(posedge clk); #1;
          load_start_i = 1'b0;
        end
      end
    end
    @(negedge clk);
    check("done_pulse", {31'd0, load_done_o}, 32'd1);
    check("done_ready", {31'd0, load_ready_o}, 32'd0);
    check("done_hold", {31'd0, cpu_hold_o}, 32'd1);
    @(negedge clk);
    check("done_clear", {31'd0, load_done_o}, 32'd0);
    check("idle_hold", {31'd0, cpu_hold_o}, 32'd0);
    check("idle_ready", {31'd0, load_ready_o}, 32'd0);
    for (int w = 0; w < cnt; w++) if (w < 64) model_mem[w] = wq[w];
    model_err = (cnt > 64);
    check("load_err", {31'd0, load_err_o}, {31'd0, model_err});
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    rom_ce_i     = 1'b1;
    rom_addr_i   = 32'd0;
    load_start_i = 1'b0;
    load_valid_i = 1'b0;
    load_byte_i  = 8'd0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", rom_data_o, 32'd0);
    check("reset_hold", {31'd0, cpu_hold_o}, 32'd0);
    check("reset_done", {31'd0, load_done_o}, 32'd0);
    check("reset_err", {31'd0, load_err_o}, 32'd0);
    rst = 1'b0;

    // Two-word load with continuous valid.
    wq = '{32'h34010010, 32'h34020020};
    run_load(2, 0, 0);
    fetch("d_addr0", 32'h0);
    check("d_addr0_const", rom_data_o, 32'h34010010);
    fetch("d_addr4", 32'h4);
    check("d_addr4_const", rom_data_o, 32'h34020020);
    fetch("d_addr7", 32'h7);
    check("d_addr7_const", rom_data_o, 32'h34020020);
    @(negedge clk);
    rom_ce_i = 1'b0;
    #1;
    check("ce_low", rom_data_o, 32'd0);
    rom_ce_i = 1'b1;

    // Same load with valid toggling every other cycle.
    reset_dut();
    fetch("post_rst", 32'h4);
    run_load(2, 1, 0);
    fetch("t_addr0", 32'h0);
    check("t_addr0_const", rom_data_o, 32'h34010010);
    fetch("t_addr4", 32'h4);
    check("t_addr4_const", rom_data_o, 32'h34020020);

    // Zero-length load leaves memory untouched.
    wq = {};
    run_load(0, 0, 0);
    fetch("z_addr0", 32'h0);
    check("z_addr0_const", rom_data_o, 32'h34010010);
    check("z_err", {31'd0, load_err_o}, 32'd0);

    // 65 words: the last is dropped and the error flag sets.
    wq = {};
    for (int i = 0; i < 65; i++) wq.push_back($urandom);
    run_load(65, 0, 0);
    check("ovf_err", {31'd0, load_err_o}, 32'd1);
    fetch("ovf_100", 32'h100);
    check("ovf_100_const", rom_data_o, 32'd0);
    fetch("ovf_0fc", 32'hFC);
    check("ovf_0fc_w63", rom_data_o, wq[63]);
    fetch("ovf_000", 32'h0);

    // Second start mid-load is ignored; a clean load clears the error.
    wq = '{32'hA1B2C3D4, 32'h0BADF00D, 32'h12345678};
    run_load(3, 0, 1);
    fetch("mid_0", 32'h0);
    fetch("mid_4", 32'h4);
    fetch("mid_8", 32'h8);
    fetch("mid_c", 32'hC);

    // Reset after the third data byte aborts the load and clears memory.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hBE, 0);
    reset_dut();
    fetch("abort_0", 32'h0);
    check("abort_0_const", rom_data_o, 32'd0);
    fetch("abort_4", 32'h4);
    fetch("abort_8", 32'h8);
    check("abort_err", {31'd0, load_err_o}, 32'd0);

    // Randomized loads with random gaps, then random fetches.
    for (int it = 0; it < 8; it++) begin
      int cnt;
      cnt = $urandom_range(6, 1);
      wq = {};
      for (int i = 0; i < cnt; i++) wq.push_back($urandom);
      run_load(cnt, $urandom_range(2, 0), 0);
      for (int f = 0; f < 8; f++) begin
        logic [31:0] a;
        a = ($urandom_range(3, 0) == 0) ? $urandom : 32'($urandom_range(40, 0));
        fetch("rand_fetch", a);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
